// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the CPU run monitor.
// Holds the monitor state encoding and the trace-signature polynomial.
package cpu_test_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

endpackage

// File: rtl/trace_misr.sv
// Multiple-input signature register folding two data words per enabled cycle.
// Clear has priority over enable; the polynomial is truncated to WIDTH.
module trace_misr
  import cpu_test_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sig
);

  localparam logic [WIDTH-1:0] poly_c = WIDTH'(MISR_POLY);

  logic [WIDTH-1:0] sig_r;
  logic [WIDTH-1:0] sig_nxt_s;

  // Next signature: clear, fold one sample, or hold.
  always_comb begin
    sig_nxt_s = sig_r;
    if (clear) begin
      sig_nxt_s = '0;
    end else if (en) begin
      sig_nxt_s = ({sig_r[WIDTH-2:0], 1'b0} ^ (sig_r[WIDTH-1] ? poly_c : '0)) ^ a ^ b;
    end else begin
      sig_nxt_s = sig_r;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sig_r <= '0;
    end else begin
      sig_r <= sig_nxt_s;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run monitor for the pipelined CPU: detects halt (PC stuck) or cycle timeout.
// Optional trace signature and signature-qualified pass under TRACE_MISR_EN.
module cpu_trace_monitor
  import cpu_test_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               HALT_CYCLES = 4,
  parameter int               MAX_CYCLES  = 1024,
  parameter logic [WIDTH-1:0] EXPECT_PC   = '0,
  parameter logic [WIDTH-1:0] EXPECT_SIG  = '0
) (
  input  logic                            clk,
  input  logic                            clrn,
  input  logic                            run,
  input  logic [WIDTH-1:0]                pc,
  input  logic [WIDTH-1:0]                alu_out,
  input  logic [WIDTH-1:0]                mem_out,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [$clog2(MAX_CYCLES+1)-1:0] cycles,
  output logic [WIDTH-1:0]                halt_pc,
  output logic [WIDTH-1:0]                sig
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] max_c  = CW'(MAX_CYCLES);
  localparam logic [SW-1:0] halt_c = SW'(HALT_CYCLES);

  mon_state_t       state_r, state_nxt_s;
  logic [CW-1:0]    cycles_r, cycles_nxt_s, cycles_inc_s;
  logic [SW-1:0]    stable_r, stable_nxt_s, stable_inc_s;
  logic [WIDTH-1:0] prev_pc_r, prev_pc_nxt_s;
  logic             prev_valid_r, prev_valid_nxt_s;
  logic             done_r, done_nxt_s;
  logic             pass_r, pass_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic [WIDTH-1:0] halt_pc_r, halt_pc_nxt_s;
  logic             start_s, sample_s;
  logic             halt_s, budget_s, sig_ok_s;

  assign cycles_inc_s = cycles_r + CW'(1);
  assign stable_inc_s = (prev_valid_r && (pc == prev_pc_r)) ? stable_r + SW'(1) : '0;
  assign halt_s       = (stable_inc_s == halt_c);
  assign budget_s     = (cycles_inc_s == max_c);

`ifdef TRACE_MISR_EN
  localparam logic [WIDTH-1:0] poly_c = WIDTH'(MISR_POLY);
  logic [WIDTH-1:0] sig_step_s;

  // The pass decision needs the signature value this sample produces.
  assign sig_step_s = ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? poly_c : '0)) ^ alu_out ^ mem_out;
  assign sig_ok_s   = (sig_step_s == EXPECT_SIG);

  trace_misr #(.WIDTH(WIDTH)) u_misr (
    .clk   (clk),
    .clrn  (clrn),
    .clear (start_s),
    .en    (sample_s),
    .a     (alu_out),
    .b     (mem_out),
    .sig   (sig)
  );
`else
  localparam logic [WIDTH-1:0] unused_sig_c = EXPECT_SIG;
  logic unused_data_s;

  assign unused_data_s = ^{alu_out, mem_out, unused_sig_c};
  assign sig_ok_s      = 1'b1;
  assign sig           = '0;
`endif

  // Next-state and next-register values of the monitor FSM.
  always_comb begin
    state_nxt_s      = state_r;
    cycles_nxt_s     = cycles_r;
    stable_nxt_s     = stable_r;
    prev_pc_nxt_s    = prev_pc_r;
    prev_valid_nxt_s = prev_valid_r;
    done_nxt_s       = done_r;
    pass_nxt_s       = pass_r;
    timeout_nxt_s    = timeout_r;
    halt_pc_nxt_s    = halt_pc_r;
    start_s          = 1'b0;
    sample_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_nxt_s      = RUN;
          start_s          = 1'b1;
          cycles_nxt_s     = '0;
          stable_nxt_s     = '0;
          prev_valid_nxt_s = 1'b0;
          done_nxt_s       = 1'b0;
          pass_nxt_s       = 1'b0;
          timeout_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (run) begin
          sample_s         = 1'b1;
          cycles_nxt_s     = cycles_inc_s;
          prev_pc_nxt_s    = pc;
          prev_valid_nxt_s = 1'b1;
          stable_nxt_s     = stable_inc_s;
          // Halt has priority when it coincides with budget exhaustion.
          if (halt_s) begin
            state_nxt_s   = HALTED;
            done_nxt_s    = 1'b1;
            halt_pc_nxt_s = pc;
            pass_nxt_s    = (pc == EXPECT_PC) && sig_ok_s;
          end else if (budget_s) begin
            state_nxt_s   = TIMEOUT;
            done_nxt_s    = 1'b1;
            timeout_nxt_s = 1'b1;
            pass_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED, TIMEOUT: begin
        if (!run) begin
          state_nxt_s   = IDLE;
          done_nxt_s    = 1'b0;
          pass_nxt_s    = 1'b0;
          timeout_nxt_s = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        done_nxt_s    = 1'b0;
        pass_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counters, PC history and result registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cycles_r     <= '0;
      stable_r     <= '0;
      prev_pc_r    <= '0;
      prev_valid_r <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      halt_pc_r    <= '0;
    end else begin
      cycles_r     <= cycles_nxt_s;
      stable_r     <= stable_nxt_s;
      prev_pc_r    <= prev_pc_nxt_s;
      prev_valid_r <= prev_valid_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
      timeout_r    <= timeout_nxt_s;
      halt_pc_r    <= halt_pc_nxt_s;
    end
  end

  assign done    = done_r;
  assign pass    = pass_r;
  assign timeout = timeout_r;
  assign cycles  = cycles_r;
  assign halt_pc = halt_pc_r;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed table, corner sequences
// and randomized episodes checked against a sample-history reference model.
module tb_cpu_trace_monitor;

`ifdef TRACE_MISR_EN
  localparam bit misr_en = 1'b1;
`else
  localparam bit misr_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        run = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] mem_out = 32'h0;

  logic        done_a, pass_a, timeout_a;
  logic [10:0] cycles_a;
  logic [31:0] halt_pc_a, sig_a;
  logic        done_b, pass_b, timeout_b;
  logic [10:0] cycles_b;
  logic [31:0] halt_pc_b, sig_b;
  logic        done_c, pass_c, timeout_c;
  logic [4:0]  cycles_c;
  logic [31:0] halt_pc_c, sig_c;
  logic        done_d, pass_d, timeout_d;
  logic [2:0]  cycles_d;
  logic [31:0] halt_pc_d, sig_d;
  logic        done_e, pass_e, timeout_e;
  logic [10:0] cycles_e;
  logic [31:0] halt_pc_e, sig_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor #(.EXPECT_PC(32'h20), .EXPECT_SIG(32'h1FFF)) u_a (
    .clk(clk), .clrn(clrn), .run(run), .pc(pc), .alu_out(alu_out), .mem_out(mem_out),
    .done(done_a), .pass(pass_a), .timeout(timeout_a), .cycles(cycles_a),
    .halt_pc(halt_pc_a), .sig(sig_a));

  cpu_trace_monitor #(.EXPECT_PC(32'h24), .EXPECT_SIG(32'h1FFF)) u_b (
    .clk(clk), .clrn(clrn), .run(run), .pc(pc), .alu_out(alu_out), .mem_out(mem_out),
    .done(done_b), .pass(pass_b), .timeout(timeout_b), .cycles(cycles_b),
    .halt_pc(halt_pc_b), .sig(sig_b));

  cpu_trace_monitor #(.MAX_CYCLES(16), .EXPECT_PC(32'h0), .EXPECT_SIG(32'h0)) u_c (
    .clk(clk), .clrn(clrn), .run(run), .pc(pc), .alu_out(alu_out), .mem_out(mem_out),
    .done(done_c), .pass(pass_c), .timeout(timeout_c), .cycles(cycles_c),
    .halt_pc(halt_pc_c), .sig(sig_c));

  cpu_trace_monitor #(.MAX_CYCLES(5), .HALT_CYCLES(4), .EXPECT_PC(32'h8), .EXPECT_SIG(32'h0)) u_d (
    .clk(clk), .clrn(clrn), .run(run), .pc(pc), .alu_out(alu_out), .mem_out(mem_out),
    .done(done_d), .pass(pass_d), .timeout(timeout_d), .cycles(cycles_d),
    .halt_pc(halt_pc_d), .sig(sig_d));

  cpu_trace_monitor #(.EXPECT_PC(32'h20), .EXPECT_SIG(32'h1FFE)) u_e (
    .clk(clk), .clrn(clrn), .run(run), .pc(pc), .alu_out(alu_out), .mem_out(mem_out),
    .done(done_e), .pass(pass_e), .timeout(timeout_e), .cycles(cycles_e),
    .halt_pc(halt_pc_e), .sig(sig_e));

  typedef struct {
    logic        run;
    logic [31:0] pc;
    logic        done;
    logic        pass;
    logic [10:0] cycles;
  } vec_t;

  vec_t tbl[15];

  // Reference model state for the randomized episodes (instance u_c).
  int          m_samples;
  int          m_runlen;
  int          m_term;
  logic [31:0] m_prev;
  logic [31:0] m_sig;
  logic [31:0] m_halt_pc;
  logic        m_pass;

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] shifted;
    shifted = s << 1;
    if (s[31]) shifted = shifted ^ 32'h04C11DB7;
    return shifted ^ a ^ b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    run = 1'b0;
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic check_c_model(input string tag);
    check({tag, "_done"}, {63'd0, done_c}, {63'd0, m_term != 0});
    check({tag, "_timeout"}, {63'd0, timeout_c}, {63'd0, m_term == 2});
    check({tag, "_pass"}, {63'd0, pass_c}, {63'd0, m_pass});
    check({tag, "_cycles"}, {59'd0, cycles_c}, 64'(m_samples));
    check({tag, "_halt_pc"}, {32'd0, halt_pc_c}, {32'd0, m_halt_pc});
    check({tag, "_sig"}, {32'd0, sig_c}, {32'd0, misr_en ? m_sig : 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_sig;

    for (int k = 0; k < 15; k++) begin
      tbl[k].run    = 1'b1;
      tbl[k].pc     = (k == 0) ? 32'hFFFF_FFF0 : ((k <= 9) ? 32'((k - 1) * 4) : 32'h20);
      tbl[k].done   = (k >= 13);
      tbl[k].pass   = (k >= 13);
      tbl[k].cycles = (k >= 13) ? 11'd13 : 11'(k);
    end

    // Reset values while clrn is held low.
    #12;
    check("rst_done", {63'd0, done_a}, 64'd0);
    check("rst_pass", {63'd0, pass_a}, 64'd0);
    check("rst_timeout", {63'd0, timeout_a}, 64'd0);
    check("rst_cycles", {53'd0, cycles_a}, 64'd0);
    check("rst_halt_pc", {32'd0, halt_pc_a}, 64'd0);
    check("rst_sig", {32'd0, sig_a}, 64'd0);
    clrn = 1'b1;

    // Directed program: PC 0..0x20 then hold, halting at 0x20.
    alu_out = 32'h1;
    mem_out = 32'h0;
    for (int i = 0; i < 15; i++) begin
      run = tbl[i].run;
      pc  = tbl[i].pc;
      step();
      check($sformatf("tbl%0d_done", i), {63'd0, done_a}, {63'd0, tbl[i].done});
      check($sformatf("tbl%0d_pass", i), {63'd0, pass_a}, {63'd0, tbl[i].pass});
      check($sformatf("tbl%0d_cycles", i), {53'd0, cycles_a}, {53'd0, tbl[i].cycles});
      check($sformatf("tbl%0d_done_b", i), {63'd0, done_b}, {63'd0, tbl[i].done});
      check($sformatf("tbl%0d_pass_b", i), {63'd0, pass_b}, 64'd0);
    end
    exp_sig = 32'h0;
    for (int i = 0; i < 13; i++) exp_sig = misr_ref(exp_sig, 32'h1, 32'h0);
    check("dir_halt_pc", {32'd0, halt_pc_a}, 64'h20);
    check("dir_timeout", {63'd0, timeout_a}, 64'd0);
    check("dir_sig", {32'd0, sig_a}, {32'd0, misr_en ? exp_sig : 32'h0});
    check("dir_halt_pc_b", {32'd0, halt_pc_b}, 64'h20);
    check("badsig_done", {63'd0, done_e}, 64'd1);
    check("badsig_pass", {63'd0, pass_e}, {63'd0, !misr_en});
    check("badsig_halt_pc", {32'd0, halt_pc_e}, 64'h20);

    // Terminal -> IDLE clears flags, keeps cycles and halt_pc.
    run = 1'b0;
    step();
    check("idle_done", {63'd0, done_a}, 64'd0);
    check("idle_pass", {63'd0, pass_a}, 64'd0);
    check("idle_cycles", {53'd0, cycles_a}, 64'd13);
    check("idle_halt_pc", {32'd0, halt_pc_a}, 64'h20);
    step();

    // Timeout: PC increments forever with a 16-sample budget.
    alu_out = 32'h0;
    run = 1'b1;
    pc  = 32'h100;
    step();
    for (int k = 1; k <= 18; k++) begin
      pc = 32'h100 + 32'(4 * k);
      step();
      check($sformatf("to%0d_cycles", k), {59'd0, cycles_c}, (k >= 16) ? 64'd16 : 64'(k));
      check($sformatf("to%0d_timeout", k), {63'd0, timeout_c}, {63'd0, k >= 16});
      check($sformatf("to%0d_done", k), {63'd0, done_c}, {63'd0, k >= 16});
    end
    check("to_pass", {63'd0, pass_c}, 64'd0);

    // Asynchronous reset clears a terminal result without a clock edge.
    @(negedge clk);
    clrn = 1'b0;
    #1;
    check("arst_done_c", {63'd0, done_c}, 64'd0);
    check("arst_timeout_c", {63'd0, timeout_c}, 64'd0);
    check("arst_cycles_c", {59'd0, cycles_c}, 64'd0);
    run = 1'b0;
    @(negedge clk);
    clrn = 1'b1;

    // Halt and budget exhaustion on the same sample: halt wins.
    run = 1'b1;
    pc  = 32'h8;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("co%0d_done", k), {63'd0, done_d}, {63'd0, k == 5});
      check($sformatf("co%0d_cycles", k), {61'd0, cycles_d}, 64'(k));
    end
    check("co_pass", {63'd0, pass_d}, 64'd1);
    check("co_timeout", {63'd0, timeout_d}, 64'd0);
    check("co_halt_pc", {32'd0, halt_pc_d}, 64'h8);

    // Pause freezes sampling; reset mid-run returns to IDLE immediately.
    hard_reset();
    run = 1'b1;
    pc  = 32'h0;
    step();
    for (int k = 0; k < 3; k++) begin
      pc = 32'(4 * k);
      step();
    end
    check("pre_pause_cycles", {53'd0, cycles_a}, 64'd3);
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h40 + 32'(4 * k);
      step();
      check($sformatf("pause%0d_cycles", k), {53'd0, cycles_a}, 64'd3);
      check($sformatf("pause%0d_done", k), {63'd0, done_a}, 64'd0);
    end
    run = 1'b1;
    pc  = 32'hC;
    step();
    pc  = 32'h10;
    step();
    check("resume_cycles", {53'd0, cycles_a}, 64'd5);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    check("midrst_cycles", {53'd0, cycles_a}, 64'd0);
    check("midrst_done", {63'd0, done_a}, 64'd0);
    check("midrst_halt_pc", {32'd0, halt_pc_a}, 64'd0);
    #2;
    clrn = 1'b1;
    step();
    check("reentry_cycles", {53'd0, cycles_a}, 64'd0);
    step();
    check("first_sample_cycles", {53'd0, cycles_a}, 64'd1);

    // Randomized episodes on the 16-sample instance against the model.
    hard_reset();
    m_halt_pc = 32'h0;
    m_sig     = 32'h0;
    m_pass    = 1'b0;
    for (int ep = 0; ep < 30; ep++) begin
      int n;
      run = 1'b1;
      pc  = $urandom;
      step();
      m_samples = 0;
      m_runlen  = 0;
      m_term    = 0;
      m_sig     = 32'h0;
      m_pass    = 1'b0;
      check_c_model($sformatf("ep%0d_entry", ep));
      n = 0;
      while (m_term == 0 && n < 100) begin
        run     = ($urandom_range(0, 4) != 0);
        pc      = ($urandom_range(0, 2) == 0) ? 32'h4 : 32'h0;
        alu_out = $urandom;
        mem_out = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        step();
        if (run) begin
          m_samples++;
          m_runlen = (m_samples > 1 && pc == m_prev) ? m_runlen + 1 : 1;
          m_prev   = pc;
          m_sig    = misr_ref(m_sig, alu_out, mem_out);
          if (m_runlen == 5) begin
            m_term    = 1;
            m_halt_pc = pc;
            m_pass    = (pc == 32'h0) && (!misr_en || m_sig == 32'h0);
          end else if (m_samples == 16) begin
            m_term = 2;
          end
        end
        check_c_model($sformatf("ep%0d_s%0d", ep, n));
        n++;
      end
      if (m_term == 0) check("episode_bound", 64'd0, 64'd1);
      step();
      check_c_model($sformatf("ep%0d_hold", ep));
      run = 1'b0;
      step();
      m_term = 0;
      m_pass = 1'b0;
      check_c_model($sformatf("ep%0d_idle", ep));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable, parametrised run monitor for the pipelined CPU. It replaces the open-ended "toggle clrn and watch waveforms" style of bring-up with a self-checking block. It sits beside `pipe_cpu` on the same clock and samples `pc`, `aluOut` and `memOut` every cycle. It detects program halt (PC stuck) or a cycle timeout, and reports done/pass together with a cycle count, the halting PC and an optional trace signature.

## Interface
Parameters:
- `WIDTH`, default 32: data and PC width.
- `HALT_CYCLES`, default 4: consecutive repeated-PC samples that define a halt (≥1).
- `MAX_CYCLES`, default 1024: sample budget before timeout (≥2).
- `EXPECT_PC`, default 0: PC at which a passing program halts.
- `EXPECT_SIG`, default 0: expected final signature (used only with the MISR feature).

Ports:
- `clk` in 1: rising-edge clock.
- `clrn` in 1: reset, asynchronous, active-low.
- `run` in 1: level enable; sampling occurs only while high.
- `pc` in WIDTH: CPU program counter.
- `alu_out` in WIDTH: CPU ALU result.
- `mem_out` in WIDTH: CPU memory read data.
- `done` out 1: run finished (halt or timeout).
- `pass` out 1: halted at `EXPECT_PC` (and signature matched, if enabled).
- `timeout` out 1: `MAX_CYCLES` exhausted without halt.
- `cycles` out $clog2(MAX_CYCLES+1): samples taken.
- `halt_pc` out WIDTH: PC at halt.
- `sig` out WIDTH: trace signature.

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT.
- Reset: state=IDLE; every output is 0; internal `prev_pc`, `prev_valid` and `stable_cnt` are 0.
- IDLE → RUN when `run`=1.
  - On entry, clear `cycles`, `sig`, `stable_cnt` and `prev_valid`.
  - `done`, `pass` and `timeout` are 0.
- RUN with `run`=1: one sample per edge.
  - `cycles` increments.
  - `prev_pc` is set to `pc` and `prev_valid` is set to 1.
  - If `prev_valid` and `pc==prev_pc`, `stable_cnt` increments; otherwise it resets to 0.
  - The signature updates (see Configuration).
- RUN with `run`=0: pause. All registers hold and no sample is taken.
- RUN → HALTED when the incremented `stable_cnt` equals `HALT_CYCLES`.
  - `done`=1 and `halt_pc`=`pc`.
  - `pass` = (`pc`==EXPECT_PC) [&& signature check].
- RUN → TIMEOUT when the incremented `cycles` equals `MAX_CYCLES` and halt is not detected on that edge.
  - `done`=1, `timeout`=1, `pass`=0.
- Simultaneous halt and budget exhaustion on the same edge: halt wins.
- HALTED/TIMEOUT are terminal while `run`=1; all outputs hold.
- HALTED/TIMEOUT → IDLE when `run`=0. This clears `done`, `pass` and `timeout`. `cycles`, `halt_pc` and `sig` hold until the next RUN entry.
- `cycles` never exceeds `MAX_CYCLES`.
- `clrn` low at any time returns the block to reset values immediately, including mid-RUN.

## Timing
- Sampling: values present before edge k are sampled at edge k.
- IDLE→RUN costs one edge. That edge takes no sample.
- `done`/`pass`/`timeout` are registered and assert on the edge that samples the halting or budget-exhausting value.
- Minimum halt latency is HALT_CYCLES+1 samples: one to load `prev_pc`, then HALT_CYCLES repeats.
- Outputs are glitch-free, driven straight from flops; there are no combinational paths from inputs to outputs.

## Configuration
- `TRACE_MISR_EN` defined:
  - Each sample computes `sig` ← ({`sig`[W-2:0],0} ^ (`sig`[W-1] ? MISR_POLY : 0)) ^ `alu_out` ^ `mem_out`.
  - `pass` additionally requires the post-update `sig`==EXPECT_SIG on the halting edge.
- Not defined:
  - `sig` is constant 0 and the signature logic is absent.
  - `pass` depends on `halt_pc` only.

## Structure
- Shared package `cpu_test_pkg` holds:
  - the state enum type `mon_state_t`;
  - `MISR_POLY` (32'h04C11DB7, truncated to WIDTH).
- Sub-module `trace_misr`: WIDTH parameter, ports `clk`, `clrn`, `clear`, `en`, `a`, `b`, `sig`. It is instantiated only under `TRACE_MISR_EN`.
- Top holds the FSM, cycle counter, stability counter and compare logic.

## Test plan
- Defaults, EXPECT_PC=0x20, macro off. PC steps 0,4,…,0x20 (9 samples), then holds 0x20. → `done`=`pass`=1 after sample 13, `cycles`=13, `halt_pc`=0x20, `timeout`=0.
- Same stimulus with EXPECT_PC=0x24. → `done`=1, `pass`=0, `halt_pc`=0x20.
- MAX_CYCLES=16, PC increments forever. → `timeout`=`done`=1 after sample 16, `cycles`=16, `pass`=0.
- MAX_CYCLES=5, HALT_CYCLES=4, PC 8 held from the first sample. → halt and budget coincide on sample 5; `pass`=1 when EXPECT_PC=8 and `timeout`=0.
- Drop `run` for 3 cycles mid-RUN, then pull `clrn` low for 1 cycle mid-RUN.
  - The pause leaves `cycles` frozen.
  - The reset zeroes all outputs asynchronously, and state returns to IDLE.
- `TRACE_MISR_EN`, `alu_out`=1, `mem_out`=0 with 1-bit shift history checked against a reference model. Then force a wrong EXPECT_SIG. → `pass`=0 with the PC still correct.
